// File: rtl/imm_gen_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// RV32I/RV64I opcodes, shift funct3 codes and the immediate format enum.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_ISH  = 3'd6
  } imm_fmt_e;

  function automatic logic is_shift_f3(logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRX);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: instruction word -> sign-extended
// XLEN immediate, format code and illegal-opcode flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // Every format fits in 32 bits before widening; bit 31 is always the sign.
  logic [31:0] imm32;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    imm32   = '0;
    fmt     = IMM_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt   = IMM_I;
      end
      OPC_OP_IMM: begin
        if (is_shift_f3(inst[14:12])) begin
          imm32 = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
          fmt   = IMM_ISH;
        end else begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
          fmt   = IMM_I;
        end
      end
      OPC_STORE: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt   = IMM_S;
      end
      OPC_BRANCH: begin
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt   = IMM_B;
      end
      OPC_JAL: begin
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt   = IMM_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {inst[31:12], 12'b0};
        fmt   = IMM_U;
      end
      OPC_OP: ;
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator with an optional 2-entry skid
// buffer so fetch and execute can stall independently.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Widths depend on module parameters, so the entry type lives here.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_valid_q;
  logic            skid_valid_q;
  logic            in_fire;
  logic            out_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};

  if (SKID_EN) begin : g_skid_ready
    assign in_ready = !skid_valid_q;
  end else begin : g_reg_ready
    assign in_ready = !out_valid_q || out_ready;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // Skid drains into the output first; a new input refills behind it.
      out_valid_q  <= skid_valid_q || in_fire;
      skid_valid_q <= skid_valid_q && in_fire;
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '{imm: '0, fmt: IMM_NONE, illegal: 1'b0, tag: '0};
    end else if (!flush && out_free && (skid_valid_q || in_fire)) begin
      out_q <= skid_valid_q ? skid_q : dec_entry;
    end
  end

  // NOTE: skid data needs no reset; skid_valid_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!flush && in_fire && (!out_free || skid_valid_q)) begin
      skid_q <= dec_entry;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against an arithmetic decode model and an in-order scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } item_t;
  item_t sb[$];

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ref_t;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID_EN(1'b1)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  // Immediate value computed as a signed number, then scaled for byte offsets.
  function automatic ref_t ref_dec(input logic [31:0] inst, input bit x64);
    longint v = 0;
    ref_t r;
    r.fmt = 3'd0;
    r.ill = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b1100111: begin v = longint'($signed(inst[31:20])); r.fmt = 3'd1; end
      7'b0010011: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          v = x64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
          r.fmt = 3'd6;
        end else begin
          v = longint'($signed(inst[31:20]));
          r.fmt = 3'd1;
        end
      end
      7'b0100011: begin v = longint'($signed({inst[31:25], inst[11:7]})); r.fmt = 3'd2; end
      7'b1100011: begin
        v = 2 * longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8]}));
        r.fmt = 3'd3;
      end
      7'b1101111: begin
        v = 2 * longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21]}));
        r.fmt = 3'd5;
      end
      7'b0110111, 7'b0010111: begin v = longint'($signed(inst[31:12])) * 4096; r.fmt = 3'd4; end
      7'b0110011: ;
      default: r.ill = 1'b1;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [10] = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1111111};
    logic [31:0] r = $urandom();
    logic [31:0] k = $urandom_range(0, 10);
    if (k == 10) return r;
    return {r[31:7], opcs[k]};
  endfunction

  // One clock with scoreboard bookkeeping; called and returns at edge+1.
  task automatic step();
    logic     in_fire, out_fire, stalled, was_flush;
    logic [67:0] h32;
    logic [99:0] h64;
    item_t    it;
    ref_t     e32, e64;
    in_fire   = in_valid && in_ready32;
    out_fire  = out_valid32 && out_ready;
    was_flush = flush;
    if (out_fire) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL out_unexpected: out_valid=1 tag=%h, required no pending item", out_tag32);
      end else begin
        it  = sb.pop_front();
        e32 = ref_dec(it.inst, 1'b0);
        e64 = ref_dec(it.inst, 1'b1);
        n_out++;
        if ({out_imm32, out_fmt32, out_illegal32, out_tag32, out_valid64,
             out_imm64, out_fmt64, out_illegal64, out_tag64} !==
            {e32.imm[31:0], e32.fmt, e32.ill, it.tag, 1'b1,
             e64.imm, e64.fmt, e64.ill, it.tag})
          $display("FAIL out_data inst=%h: got32 %h/%0d/%b/%h got64 %h/%0d/%b/%h, required %h/%0d/%b/%h and %h/%0d/%b",
                   it.inst, out_imm32, out_fmt32, out_illegal32, out_tag32,
                   out_imm64, out_fmt64, out_illegal64, out_tag64,
                   e32.imm[31:0], e32.fmt, e32.ill, it.tag, e64.imm, e64.fmt, e64.ill);
        else n_pass++;
      end
    end
    if (in_fire && !flush) sb.push_back('{inst: in_inst, tag: in_tag});
    stalled = out_valid32 && !out_ready && !flush;
    h32 = {out_imm32, out_fmt32, out_illegal32, out_tag32};
    h64 = {out_imm64, out_fmt64, out_illegal64, out_tag64};
    @(posedge clk);
    #1;
    if (was_flush) sb.delete();
    if (stalled) begin
      n_checks++;
      if ({out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32,
           out_imm64, out_fmt64, out_illegal64, out_tag64} !== {1'b1, h32, h64})
        $display("FAIL stall_hold: out32 %h out64 %h, required held %h / %h",
                 {out_imm32, out_fmt32, out_illegal32, out_tag32},
                 {out_imm64, out_fmt64, out_illegal64, out_tag64}, h32, h64);
      else n_pass++;
    end
    n_checks++;
    if ({out_valid32, in_ready32, out_valid64, in_ready64} !==
        {sb.size() > 0, sb.size() < 2, sb.size() > 0, sb.size() < 2})
      $display("FAIL occupancy: ov32=%b ir32=%b ov64=%b ir64=%b, required ov=%b ir=%b (pending %0d)",
               out_valid32, in_ready32, out_valid64, in_ready64,
               sb.size() > 0, sb.size() < 2, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32,
         out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64} !== '0)
      $display("FAIL reset_outputs: v=%b imm=%h fmt=%0d ill=%b tag=%h / imm64=%h, required all zero",
               out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32, out_imm64);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready32, in_ready64, out_valid32, out_valid64, out_imm32, out_tag32} !== {4'b1100, 64'h0})
      $display("FAIL reset_release: in_ready=%b%b out_valid=%b%b imm=%h tag=%h, required in_ready=1 out_valid=0 zeros",
               in_ready32, in_ready64, out_valid32, out_valid64, out_imm32, out_tag32);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] insts [10] = '{32'hFFF00093, 32'hFE000EE3, 32'h0000006F, 32'h800000EF, 32'h12345037,
                                32'h0FF0A023, 32'h00000000, 32'h03F09093, 32'h80000037, 32'h00B50533};
    logic [31:0] exp32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'hFFF00000, 32'h12345000,
                                32'h000000E0, 32'h0, 32'h0000001F, 32'h80000000, 32'h0};
    logic [63:0] exp64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'hFFFFFFFFFFF00000,
                                64'h12345000, 64'hE0, 64'h0, 64'h3F, 64'hFFFFFFFF80000000, 64'h0};
    logic [2:0]  fmts  [10] = '{3'd1, 3'd3, 3'd5, 3'd5, 3'd4, 3'd2, 3'd0, 3'd6, 3'd4, 3'd0};
    logic        ills  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_inst  = insts[i];
      in_tag   = 32'hA000 + i;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32,
           out_valid64, out_imm64, out_fmt64, out_illegal64} !==
          {1'b1, exp32[i], fmts[i], ills[i], 32'hA000 + i, 1'b1, exp64[i], fmts[i], ills[i]})
        $display("FAIL directed_%h: v=%b imm32=%h imm64=%h fmt=%0d/%0d ill=%b/%b tag=%h, required imm32=%h imm64=%h fmt=%0d ill=%b",
                 insts[i], out_valid32, out_imm32, out_imm64, out_fmt32, out_fmt64,
                 out_illegal32, out_illegal64, out_tag32, exp32[i], exp64[i], fmts[i], ills[i]);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [4];
    int idx = 0;
    int out0 = n_out;
    for (int i = 0; i < 4; i++) insts[i] = rand_inst();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_inst  = insts[idx];
      in_tag   = 32'h100 + idx;
      if (in_ready32) idx++;
      step();
    end
    n_checks++;
    if (idx != 2 || in_ready32 !== 1'b0)
      $display("FAIL bp_accepts: accepted %0d in_ready=%b, required 2 accepted and in_ready=0", idx, in_ready32);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || sb.size() > 0); c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_inst = insts[idx];
        in_tag  = 32'h100 + idx;
      end
      if (in_valid && in_ready32) idx++;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out - out0 != 4 || sb.size() != 0)
      $display("FAIL bp_drain: emitted %0d pending %0d, required 4 emitted 0 pending", n_out - out0, sb.size());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_inst   = rand_inst();
      in_tag    = $urandom();
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) step();
    n_checks++;
    if (sb.size() != 0 || out_valid32 !== 1'b0)
      $display("FAIL random_drain: pending %0d out_valid=%b, required 0 pending out_valid=0", sb.size(), out_valid32);
    else n_pass++;
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_inst  = rand_inst();
      in_tag   = 32'h200 + c;
      step();
    end
    flush    = 1'b1;
    in_inst  = rand_inst();
    in_tag   = 32'h2FF;
    step();
    flush    = 1'b0;
    n_checks++;
    if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b0101)
      $display("FAIL flush_full: out_valid=%b%b in_ready=%b%b, required out_valid=0 in_ready=1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_inst  = rand_inst();
      in_tag   = 32'h300 + c;
      step();
    end
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid32, out_valid64, out_imm32, out_tag32} !== '0)
      $display("FAIL async_reset: out_valid=%b%b imm=%h tag=%h, required all zero immediately",
               out_valid32, out_valid64, out_imm32, out_tag32);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid32, in_ready32} !== 2'b01)
      $display("FAIL reset_recover: out_valid=%b in_ready=%b, required 0/1", out_valid32, in_ready32);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
